// File: rtl/result_ser_if.sv
// Result serializer bus: push side (producer -> FIFO) and byte stream side
// (serializer -> consumer), plus the rejected-push counter.
interface result_ser_if #(
  parameter int unsigned WIDTH = 16
);
  logic             push;
  logic [WIDTH:0]   din;
  logic             full;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             out_last;
  logic [7:0]       drop_cnt;

  // Producer/consumer side: drives pushes and out_ready.
  modport master (
    output push, din, out_ready,
    input  full, out_valid, out_byte, out_last, drop_cnt
  );

  // Serializer side.
  modport slave (
    input  push, din, out_ready,
    output full, out_valid, out_byte, out_last, drop_cnt
  );
endinterface

// File: rtl/result_ser.sv
// result_ser: queues WIDTH+1-bit adder results in a DEPTH-entry FIFO and
// streams each one out LSB byte first over a valid/ready byte interface.
// Optional feature: define RESULT_SER_DROP_CNT_EN to count rejected pushes
// (saturating at 255); otherwise drop_cnt is tied to zero.
module result_ser #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  result_ser_if.slave  bus
);

  localparam int unsigned DW     = WIDTH + 1;
  localparam int unsigned NBYTES = (DW + 7) / 8;
  localparam int unsigned PW     = NBYTES * 8;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned IDX_W  = $clog2(NBYTES) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [DW-1:0]      shreg_q, shreg_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_byte_q, out_byte_d;
  logic               out_last_q, out_last_d;
  logic               full_q, full_d;

  logic               full_pre;
  logic               push_acc;
  logic               pop;
  logic [PW-1:0]      pad_d;

  // Acceptance is decided from pre-edge occupancy only.
  always_comb begin
    full_pre = (count_q == CNT_W'(DEPTH));
    push_acc = bus.push && !full_pre;
  end

  // Serializer FSM: next state, shift register, byte index and head pop.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          shreg_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (byte_idx_q == IDX_W'(NBYTES - 1)) begin
            if (count_q != '0) begin
              // back-to-back results: reload without a bubble
              pop        = 1'b1;
              shreg_d    = mem_q[rd_ptr_q];
              byte_idx_d = '0;
            end else begin
              shreg_d    = '0;
              byte_idx_d = '0;
              state_d    = IDLE;
            end
          end else begin
            shreg_d    = shreg_q >> 8;
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers and occupancy (wrap naturally, DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_acc) - CNT_W'(pop);
  end

  // Registered outputs derived from next-state values.
  always_comb begin
    pad_d       = PW'(shreg_d);
    out_valid_d = (state_d == SEND);
    out_byte_d  = out_valid_d ? pad_d[7:0] : 8'h00;
    out_last_d  = out_valid_d && (byte_idx_d == IDX_W'(NBYTES - 1));
    full_d      = (count_d == CNT_W'(DEPTH));
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      byte_idx_q  <= '0;
      shreg_q     <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_last_q  <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      byte_idx_q  <= byte_idx_d;
      shreg_q     <= shreg_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      full_q      <= full_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_last  = out_last_q;
  assign bus.full      = full_q;

`ifdef RESULT_SER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of pushes rejected because the FIFO was full.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.push && full_pre && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_result_ser.sv
// Testbench for result_ser: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the result stream.
module tb_result_ser;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NBYTES = 3;

`ifdef RESULT_SER_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  result_ser_if #(.WIDTH(WIDTH)) bus ();

  result_ser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: queued results, remaining bytes of the result on the
  // wire, and the rejected-push count.
  logic [WIDTH:0] m_fifo [$];
  logic [7:0]     m_bytes [$];
  int             m_drop;

  int checks = 0;
  int errors = 0;

  function automatic void m_load();
    logic [WIDTH:0] v;
    v = m_fifo.pop_front();
    m_bytes.delete();
    for (int i = 0; i < NBYTES; i++) m_bytes.push_back(8'(v >> (8 * i)));
  endfunction

  function automatic void m_edge(input logic p, input logic [WIDTH:0] d, input logic r);
    bit full_pre;
    logic [7:0] sent;
    full_pre = (m_fifo.size() == DEPTH);
    if (m_bytes.size() != 0) begin
      if (r) begin
        sent = m_bytes.pop_front();
        if (m_bytes.size() == 0 && m_fifo.size() != 0) m_load();
      end
    end else if (m_fifo.size() != 0) begin
      m_load();
    end
    if (p) begin
      if (!full_pre) m_fifo.push_back(d);
      else if (DROP_EN && m_drop < 255) m_drop++;
    end
  endfunction

  function automatic void m_clear();
    m_fifo.delete();
    m_bytes.delete();
    m_drop = 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] eb;
    eb = (m_bytes.size() != 0) ? m_bytes[0] : 8'h00;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(m_bytes.size() != 0));
    check({tag, "_byte"},  32'(bus.out_byte),  32'(eb));
    check({tag, "_last"},  32'(bus.out_last),  32'(m_bytes.size() == 1));
    check({tag, "_full"},  32'(bus.full),      32'(m_fifo.size() == DEPTH));
    check({tag, "_drop"},  32'(bus.drop_cnt),  32'(m_drop));
  endtask

  // One clock: inputs applied just after an edge, model advanced on the
  // next edge, outputs sampled 1 time unit later.
  task automatic step(input logic p, input logic [WIDTH:0] d, input logic r, input string tag);
    bus.push      = p;
    bus.din       = d;
    bus.out_ready = r;
    @(posedge clk);
    m_edge(p, d, r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.push      = 1'b0;
    bus.din       = '0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_last",  32'(bus.out_last),  32'd0);
    check("rst_byte",  32'(bus.out_byte),  32'd0);
    check("rst_full",  32'(bus.full),      32'd0);
    check("rst_drop",  32'(bus.drop_cnt),  32'd0);
    m_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, tag);
  endtask

  logic [7:0] got [6];
  logic [7:0] exp32 [6];

  initial begin
    rst           = 1'b0;
    bus.push      = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b0;
    #2;
    do_reset();

    // Single result, consumer always ready.
    step(1'b1, 17'h1_ABCD, 1'b1, "r31");
    check("r31_lat_edge1", 32'(bus.out_valid), 32'd0);
    step(1'b0, '0, 1'b1, "r31");
    check("r31_b0", 32'(bus.out_byte), 32'h0CD);
    check("r31_v0", 32'(bus.out_valid), 32'd1);
    step(1'b0, '0, 1'b1, "r31");
    check("r31_b1", 32'(bus.out_byte), 32'h0AB);
    step(1'b0, '0, 1'b1, "r31");
    check("r31_b2", 32'(bus.out_byte), 32'h001);
    check("r31_last", 32'(bus.out_last), 32'd1);
    step(1'b0, '0, 1'b1, "r31");
    check("r31_done", 32'(bus.out_valid), 32'd0);

    // Two results back-to-back: six bytes, no gap.
    exp32[0] = 8'h34; exp32[1] = 8'h12; exp32[2] = 8'h00;
    exp32[3] = 8'hFF; exp32[4] = 8'hFF; exp32[5] = 8'h01;
    step(1'b1, 17'h0_1234, 1'b1, "r32");
    step(1'b1, 17'h1_FFFF, 1'b1, "r32");
    got[0] = bus.out_byte;
    for (int i = 1; i < 6; i++) begin
      step(1'b0, '0, 1'b1, "r32");
      check($sformatf("r32_valid%0d", i), 32'(bus.out_valid), 32'd1);
      got[i] = bus.out_byte;
    end
    for (int i = 0; i < 6; i++) check($sformatf("r32_byte%0d", i), 32'(got[i]), 32'(exp32[i]));
    step(1'b0, '0, 1'b1, "r32");
    check("r32_done", 32'(bus.out_valid), 32'd0);

    // Consumer stall in the middle of a result.
    step(1'b1, 17'h1_5A3C, 1'b1, "r33");
    step(1'b0, '0, 1'b1, "r33");
    step(1'b0, '0, 1'b1, "r33");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, "r33_stall");
      check("r33_hold_byte", 32'(bus.out_byte), 32'h05A);
      check("r33_hold_last", 32'(bus.out_last), 32'd0);
    end
    step(1'b0, '0, 1'b1, "r33");
    check("r33_resume", 32'(bus.out_byte), 32'h001);
    check("r33_resume_last", 32'(bus.out_last), 32'd1);
    drain("r33_drain");

    // Fill with consumer stalled: full after five pushes, sixth dropped.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, (WIDTH+1)'($urandom), 1'b0, "r34");
      if (i == 4) check("r34_notfull4", 32'(bus.full), 32'd0);
      if (i == 5) check("r34_full5", 32'(bus.full), 32'd1);
    end
    check("r34_drop", 32'(bus.drop_cnt), DROP_EN ? 32'd1 : 32'd0);
    drain("r34_drain");

    // Many pushes while full: drop counter saturation.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, (WIDTH+1)'($urandom), 1'b0, "r36_fill");
    for (int i = 0; i < 300; i++) step(1'b1, (WIDTH+1)'($urandom), 1'b0, "r36");
    check("r36_sat", 32'(bus.drop_cnt), DROP_EN ? 32'd255 : 32'd0);
    drain("r36_drain");

    // Reset during the 2nd byte with two results queued behind it.
    do_reset();
    step(1'b1, 17'h0_1111, 1'b1, "r35");
    step(1'b1, 17'h1_2222, 1'b1, "r35");
    step(1'b1, 17'h0_3333, 1'b1, "r35");
    check("r35_byte1", 32'(bus.out_byte), 32'h011);
    do_reset();
    check("r35_after_rel", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1, "r35_idle");
      check("r35_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Randomized traffic: mostly-ready then mostly-stalled consumer.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), (WIDTH+1)'($urandom),
           1'($urandom_range(0, 3) != 0), "rnd_fast");
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), (WIDTH+1)'($urandom),
           1'($urandom_range(0, 3) == 0), "rnd_slow");
    drain("rnd_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
